// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, optional overlapping
// matches and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1011,
  parameter bit               OVERLAP     = 1'b1,
  parameter int               CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cnt_clr,
  output logic               match,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  // Handshake: in_bit is consumed on a rising edge where in_valid=1 and
  // cfg_load=0; there is no backpressure, so the detector is always ready.

  localparam int              FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FULL = FW'(PAT_LEN);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  logic [PAT_LEN-1:0] sh;
  logic [PAT_LEN-1:0] pat;
  logic [FW-1:0]      fill;
  state_t             state;

  logic               accept;
  logic [PAT_LEN-1:0] sh_n;
  logic [FW-1:0]      fill_n;
  logic               hit;

  // State is a pure decode of the fill counter, so it can never disagree with it.
  assign state = (fill == FULL) ? ARMED : FILL;
  assign armed = (state == ARMED);

  always_comb begin
    accept = in_valid & ~cfg_load;
    sh_n   = {sh[PAT_LEN-2:0], in_bit};
    fill_n = (fill == FULL) ? FULL : fill + 1'b1;
    hit    = accept && (fill_n == FULL) && (sh_n == pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      fill  <= '0;
      pat   <= RST_PATTERN;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat   <= cfg_pattern;
      sh    <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (accept) begin
      sh    <= sh_n;
      // Non-overlapping mode forces a full refill before the next match.
      fill  <= (hit && (OVERLAP == 1'b0)) ? '0 : fill_n;
      match <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  assign cnt_sat = &match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && !cnt_sat) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: one overlapping and one non-overlapping
// instance driven by the same stimulus, each checked against hand-derived values.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cnt_clr;

  logic       match_ov, armed_ov, sat_ov;
  logic [7:0] cnt_ov;
  logic       match_no, armed_no, sat_no;
  logic [7:0] cnt_no;

  int vec_cnt = 0;
  int err_cnt = 0;

  seq_detect_param #(.PAT_LEN(4), .RST_PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .match(match_ov), .armed(armed_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov)
  );

  seq_detect_param #(.PAT_LEN(4), .RST_PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .match(match_no), .armed(armed_no), .match_cnt(cnt_no), .cnt_sat(sat_no)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are sampled #1 after the rising edge.
  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] p,
                      input logic clr);
    @(negedge clk);
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = p;
    cnt_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    step(1'b1, b, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [6:0] s31;
  logic [6:0] m31_ov;
  logic [6:0] m31_no;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cfg_load = 1'b0; cfg_pattern = 4'h0; cnt_clr = 1'b0;
    #12;
    chk("rst_match", {match_ov, match_no}, 2'b00);
    chk("rst_armed", {armed_ov, armed_no}, 2'b00);
    chk("rst_cnt",   {cnt_ov, cnt_no}, 16'h0000);
    chk("rst_sat",   {sat_ov, sat_no}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,1,1,0,1,1: overlapping matches at bits 4 and 7, non-overlapping at bit 4 only
    s31    = 7'b1011011;
    m31_ov = 7'b0001001;
    m31_no = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      send(s31[i]);
      chk($sformatf("ov_match_b%0d", 7 - i), match_ov, m31_ov[i]);
      chk($sformatf("no_match_b%0d", 7 - i), match_no, m31_no[i]);
      chk($sformatf("no_armed_b%0d", 7 - i), armed_no, 1'b0);
    end
    chk("ov_cnt_2", cnt_ov, 8'd2);
    chk("no_cnt_1", cnt_no, 8'd1);
    chk("ov_armed", armed_ov, 1'b1);
    send(1'b1);
    chk("no_armed_refill", armed_no, 1'b1);
    chk("no_match_0111", {match_ov, match_no}, 2'b00);

    // restart via cfg_load with the same pattern; gap in valid must not disturb progress
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    chk("ld_armed", {armed_ov, armed_no}, 2'b00);
    send(1'b1); send(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("idle_match_%0d", i), {match_ov, match_no}, 2'b00);
    end
    send(1'b1);
    chk("gap_b3", {match_ov, match_no}, 2'b00);
    send(1'b1);
    chk("gap_match", {match_ov, match_no}, 2'b11);
    idle();
    chk("pulse_one_cycle", {match_ov, match_no}, 2'b00);
    chk("gap_cnt", {cnt_ov, cnt_no}, {8'd3, 8'd2});

    // 0,1,1 then load 0110 with a coincident valid bit that must be discarded
    send(1'b0); send(1'b1); send(1'b1);
    chk("pre_ld_match", {match_ov, match_no}, 2'b10);
    step(1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    chk("ld2_match", {match_ov, match_no}, 2'b00);
    chk("ld2_cnt", {cnt_ov, cnt_no}, {8'd4, 8'd2});
    send(1'b0); send(1'b1); send(1'b1);
    chk("ld2_discard_armed", {armed_ov, armed_no}, 2'b00);
    chk("ld2_b3_match", {match_ov, match_no}, 2'b00);
    send(1'b0);
    chk("ld2_match_0110", {match_ov, match_no}, 2'b11);
    chk("ld2_cnt_inc", {cnt_ov, cnt_no}, {8'd5, 8'd3});

    // asynchronous reset mid-pattern, checked while held low
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_match", {match_ov, match_no}, 2'b00);
    chk("arst_cnt", {cnt_ov, cnt_no}, 16'h0000);
    chk("arst_flags", {armed_ov, armed_no, sat_ov, sat_no}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1);
    chk("post_rst_b1", {match_ov, match_no}, 2'b00);
    send(1'b1); send(1'b0); send(1'b1);
    chk("post_rst_b4", {match_ov, match_no}, 2'b00);
    send(1'b1);
    chk("post_rst_match", {match_ov, match_no}, 2'b11);
    chk("post_rst_cnt", {cnt_ov, cnt_no}, {8'd1, 8'd1});

    // saturation: pattern 1111 matches on every bit once armed in overlap mode
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("clr_cnt", {cnt_ov, cnt_no}, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 257; i++) send(1'b1);
    chk("sat_cnt_254", cnt_ov, 8'd254);
    chk("sat_flag_254", sat_ov, 1'b0);
    chk("no_cnt_64", cnt_no, 8'd64);
    send(1'b1);
    chk("sat_cnt_255a", cnt_ov, 8'd255);
    send(1'b1);
    chk("sat_cnt_255b", cnt_ov, 8'd255);
    chk("sat_flag", sat_ov, 1'b1);
    chk("sat_match", match_ov, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("clr_hit_match", match_ov, 1'b1);
    chk("clr_hit_cnt", cnt_ov, 8'd0);
    chk("clr_hit_sat", sat_ov, 1'b0);
    chk("clr_no_cnt", cnt_no, 8'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 4: detected pattern length in bits; legal range 2..16.
REQ-002 Parameter RST_PATTERN, default 4'b1011 (PAT_LEN bits): pattern loaded at reset; MSB is the first bit received in time.
REQ-003 Parameter OVERLAP, default 1: 1 means overlapping matches allowed; 0 means the search restarts after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 in_valid  in  1  in_bit is accepted on a rising edge only when 1.
REQ-008 in_bit  in  1  serial data bit.
REQ-009 cfg_load  in  1  loads cfg_pattern at the rising edge.
REQ-010 cfg_pattern  in  PAT_LEN  new pattern; MSB is first in time.
REQ-011 cnt_clr  in  1  synchronous clear of the match counter.
REQ-012 match  out  1  registered one-cycle pulse on a detected pattern.
REQ-013 armed  out  1  high when PAT_LEN valid bits are held since the last restart.
REQ-014 match_cnt  out  CNT_W  saturating count of matches.
REQ-015 cnt_sat  out  1  high while match_cnt equals all-ones.

Function
REQ-016 Internal state: shift register sh[PAT_LEN-1:0], fill counter fill (0..PAT_LEN), active pattern register pat.
REQ-017 Two states, decoded from fill: FILL (fill<PAT_LEN) and ARMED (fill==PAT_LEN); armed = (state==ARMED).
REQ-018 Accepted bit (in_valid=1, cfg_load=0): sh_n = {sh[PAT_LEN-2:0], in_bit}; fill_n = min(fill+1, PAT_LEN).
REQ-019 A hit exists at an accepted edge when fill_n==PAT_LEN and sh_n==pat, comparing all PAT_LEN bits.
REQ-020 match is registered at the same edge: it is 1 for exactly the clock cycle after the edge that accepted the completing bit (latency 1); otherwise match is 0.
REQ-021 in_valid=0: sh, fill and counter hold; match is 0 in the next cycle.
REQ-022 OVERLAP=1 on a hit: sh_n and fill_n update as in REQ-018, so a suffix of the pattern can start the next match.
REQ-023 OVERLAP=0 on a hit: fill becomes 0 and state becomes FILL; PAT_LEN further accepted bits are needed before the next match.
REQ-024 cfg_load=1: pat <= cfg_pattern, sh <= 0, fill <= 0, match <= 0; an in_bit on the same edge is discarded; match_cnt is unaffected.
REQ-025 Counter on a hit: match_cnt increments by 1, saturating at 2^CNT_W-1 with no wrap; cnt_sat is combinational from match_cnt.
REQ-026 cnt_clr=1: match_cnt <= 0 and overrides a simultaneous hit increment; the match pulse itself is still produced.
REQ-027 Priority, highest first: rst_n, cfg_load, then bit acceptance; cnt_clr acts only on the counter.

Reset
REQ-028 rst_n=0 asynchronously forces: sh=0, fill=0, pat=RST_PATTERN, match=0, match_cnt=0; hence armed=0 and cnt_sat=0.
REQ-029 Reset asserted mid-pattern discards partial progress; after release, a full PAT_LEN bits are needed before the next match.
REQ-030 Outputs are stable from the first rising edge after rst_n deasserts.

Verification (PAT_LEN=4, pattern 1011, CNT_W=8)
REQ-031 OVERLAP=1; bits 1,0,1,1,0,1,1 on consecutive valid cycles -> match pulses after the 4th and 7th bits; match_cnt=2.
REQ-032 OVERLAP=0; same stream -> single match after the 4th bit; match_cnt=1; armed=0 after that match until 4 more bits are accepted.
REQ-033 Bits 1,0 then in_valid=0 for 3 cycles then bits 1,1 -> single match after the final bit; no match during the idle cycles.
REQ-034 cfg_load with 0110 after bits 0,1,1 -> no match from the prior bits; fresh 0,1,1,0 -> match; match_cnt keeps its prior value +1.
REQ-035 Force match_cnt to 254, then 2 further matches -> 255 with cnt_sat=1, no wrap; cnt_clr coincident with a hit -> match=1 and match_cnt=0.
REQ-036 rst_n low after bits 1,0,1 then released; bit 1 -> no match; 1,0,1,1 -> match; reset values are checked while rst_n is low.
